// File: rtl/paddle_ctrl.sv
// Pong paddle controller: synchronizes the up/down buttons, moves the paddle once per frame
// with a hold-to-accelerate speed FSM, clamps it to the visible area and flags paddle pixels.
module paddle_ctrl #(
    parameter int HMAX        = 800,
    parameter int VMAX        = 525,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int PADDLE_X    = 16,
    parameter int PADDLE_W    = 8,
    parameter int PADDLE_H    = 64,
    parameter int SPEED_SLOW  = 2,
    parameter int SPEED_FAST  = 6,
    parameter int HOLD_FRAMES = 15
) (
    input  logic                          i_Clk,
    input  logic                          i_Rst,
    input  logic [$clog2(HMAX)-1:0]       i_H_count,
    input  logic [$clog2(VMAX)-1:0]       i_V_count,
    input  logic                          i_Frame_end,
    input  logic                          i_Up,
    input  logic                          i_Down,
    output logic [$clog2(V_ACTIVE)-1:0]   o_Paddle_Y,
    output logic [1:0]                    o_State,
    output logic                          o_Draw
);

    localparam int HW  = $clog2(HMAX);
    localparam int VW  = $clog2(VMAX);
    localparam int YW  = $clog2(V_ACTIVE);
    localparam int CW  = $clog2(HOLD_FRAMES + 2);
    localparam int VXW = VW + 1;

    localparam logic [YW-1:0] YMAX      = YW'(V_ACTIVE - PADDLE_H);
    localparam logic [YW-1:0] Y_RST     = YW'((V_ACTIVE - PADDLE_H) / 2);
    localparam logic [YW-1:0] STEP_SLOW = YW'(SPEED_SLOW);
    localparam logic [YW-1:0] STEP_FAST = YW'(SPEED_FAST);
    localparam logic [CW-1:0] CNT_HOLD  = CW'(HOLD_FRAMES);
    localparam logic [CW-1:0] CNT_SAT   = CW'(HOLD_FRAMES + 1);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SLOW = 2'd1, ST_FAST = 2'd2} state_t;
    typedef enum logic [1:0] {DIR_NONE = 2'd0, DIR_UP = 2'd1, DIR_DOWN = 2'd2} dir_t;

    logic          r_up_meta, r_up_sync, r_dn_meta, r_dn_sync;
    state_t        r_state, w_state_next;
    logic [CW-1:0] r_cnt, w_cnt_next, w_cnt_inc;
    dir_t          r_last_dir, w_last_dir_next, w_dir, w_move_dir;
    logic [YW-1:0] r_y, w_y_next, w_step;
    logic [YW:0]   w_sum;
    logic          r_draw, w_h_in, w_v_in;
    logic [VXW-1:0] w_v_ext, w_y_top, w_y_bot;

    // Two-flop synchronizers for the asynchronous buttons
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_up_meta <= 1'b0;
            r_up_sync <= 1'b0;
            r_dn_meta <= 1'b0;
            r_dn_sync <= 1'b0;
        end else begin
            r_up_meta <= i_Up;
            r_up_sync <= r_up_meta;
            r_dn_meta <= i_Down;
            r_dn_sync <= r_dn_meta;
        end
    end

    // Direction decode: both or neither pressed means no movement
    always_comb begin
        w_dir = DIR_NONE;
        if (r_up_sync && !r_dn_sync) begin
            w_dir = DIR_UP;
        end else if (r_dn_sync && !r_up_sync) begin
            w_dir = DIR_DOWN;
        end else begin
            w_dir = DIR_NONE;
        end
    end

    // Speed FSM next state; only acts on the frame-end strobe
    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        w_last_dir_next = r_last_dir;
        w_move_dir      = DIR_NONE;
        w_step          = '0;
        w_cnt_inc       = (r_cnt == CNT_SAT) ? r_cnt : r_cnt + CW'(1);
        if (!i_Frame_end) begin
            w_state_next = r_state;
        end else if (w_dir == DIR_NONE) begin
            w_state_next = ST_IDLE;
            w_cnt_next   = '0;
        end else if ((r_state == ST_IDLE) || (w_dir != r_last_dir)) begin
            w_state_next    = ST_SLOW;
            w_cnt_next      = CW'(1);
            w_last_dir_next = w_dir;
            w_move_dir      = w_dir;
            w_step          = STEP_SLOW;
        end else begin
            w_cnt_next = w_cnt_inc;
            w_move_dir = w_dir;
            if (w_cnt_inc > CNT_HOLD) begin
                w_state_next = ST_FAST;
                w_step       = STEP_FAST;
            end else begin
                w_state_next = ST_SLOW;
                w_step       = STEP_SLOW;
            end
        end
    end

    // Clamped position update; the sum is one bit wider so it cannot wrap
    always_comb begin
        w_y_next = r_y;
        w_sum    = {1'b0, r_y} + {1'b0, w_step};
        case (w_move_dir)
            DIR_UP:   w_y_next = (r_y < w_step) ? '0 : r_y - w_step;
            DIR_DOWN: w_y_next = (w_sum > {1'b0, YMAX}) ? YMAX : w_sum[YW-1:0];
            default:  w_y_next = r_y;
        endcase
    end

    // FSM, hold counter and position registers
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_last_dir <= DIR_NONE;
            r_y        <= Y_RST;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_last_dir <= w_last_dir_next;
            r_y        <= w_y_next;
        end
    end

    // Paddle hit test against the current beam position
    always_comb begin
        w_v_ext = VXW'(i_V_count);
        w_y_top = VXW'(r_y);
        w_y_bot = w_y_top + VXW'(PADDLE_H);
        w_h_in  = (i_H_count >= HW'(PADDLE_X)) && (i_H_count < HW'(PADDLE_X + PADDLE_W)) &&
                  (i_H_count < HW'(H_ACTIVE));
        w_v_in  = (w_v_ext >= w_y_top) && (w_v_ext < w_y_bot) && (i_V_count < VW'(V_ACTIVE));
    end

    // Registered draw flag, one cycle behind H/V
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_draw <= 1'b0;
        end else begin
            r_draw <= w_h_in && w_v_in;
        end
    end

    assign o_Paddle_Y = r_y;
    assign o_State    = r_state;
    assign o_Draw     = r_draw;

endmodule

// File: tb/tb_paddle_ctrl.sv
// Directed self-checking bench for paddle_ctrl: reset, draw window, acceleration,
// clamping at both limits, direction reversal and frame-end gating.
module tb_paddle_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] h_count, v_count;
    logic       frame_end, up, down;
    logic [8:0] paddle_y;
    logic [1:0] state;
    logic       draw;
    int         checks = 0;
    int         errors = 0;

    paddle_ctrl dut (
        .i_Clk       (clk),
        .i_Rst       (rst),
        .i_H_count   (h_count),
        .i_V_count   (v_count),
        .i_Frame_end (frame_end),
        .i_Up        (up),
        .i_Down      (down),
        .o_Paddle_Y  (paddle_y),
        .o_State     (state),
        .o_Draw      (draw)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            frame_end = 1'b1;
            tick();
            frame_end = 1'b0;
            tick();
        end
    endtask

    task automatic set_buttons(input logic u, input logic d);
        up   = u;
        down = d;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; frame_end = 1'b0; up = 1'b0; down = 1'b0;
        h_count = 10'd0; v_count = 10'd0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        checks++;
        if (paddle_y !== 9'd208) begin errors++; $display("FAIL reset_y: got %0d expected 208", paddle_y); end
        checks++;
        if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
        checks++;
        if (draw !== 1'b0) begin errors++; $display("FAIL reset_draw: got %0d expected 0", draw); end
    endtask

    task automatic test_draw();
        logic [9:0] hv [8][2];
        logic       exp [8];
        hv = '{'{10'd16, 10'd208}, '{10'd24, 10'd208}, '{10'd23, 10'd208}, '{10'd15, 10'd208},
               '{10'd16, 10'd272}, '{10'd16, 10'd271}, '{10'd16, 10'd207}, '{10'd20, 10'd240}};
        exp = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 8; i++) begin
            h_count = hv[i][0];
            v_count = hv[i][1];
            tick();
            checks++;
            if (draw !== exp[i]) begin
                errors++;
                $display("FAIL draw_%0d (H=%0d V=%0d): got %0d expected %0d", i, h_count, v_count, draw, exp[i]);
            end
        end
        h_count = 10'd0; v_count = 10'd0;
        tick();
    endtask

    task automatic test_accel();
        set_buttons(1'b1, 1'b0);
        frames(15);
        checks++;
        if (paddle_y !== 9'd178) begin errors++; $display("FAIL slow15_y: got %0d expected 178", paddle_y); end
        checks++;
        if (state !== 2'd1) begin errors++; $display("FAIL slow15_state: got %0d expected 1", state); end
        frames(1);
        checks++;
        if (paddle_y !== 9'd172) begin errors++; $display("FAIL fast16_y: got %0d expected 172", paddle_y); end
        checks++;
        if (state !== 2'd2) begin errors++; $display("FAIL fast16_state: got %0d expected 2", state); end
    endtask

    task automatic test_clamp_top();
        frames(28);
        checks++;
        if (paddle_y !== 9'd4) begin errors++; $display("FAIL near_top_y: got %0d expected 4", paddle_y); end
        frames(1);
        checks++;
        if (paddle_y !== 9'd0) begin errors++; $display("FAIL clamp_top_y: got %0d expected 0", paddle_y); end
        frames(3);
        checks++;
        if (paddle_y !== 9'd0) begin errors++; $display("FAIL pinned_top_y: got %0d expected 0", paddle_y); end
        checks++;
        if (state !== 2'd2) begin errors++; $display("FAIL pinned_top_state: got %0d expected 2", state); end
    endtask

    task automatic test_reset_mid_frame();
        h_count = 10'd16; v_count = 10'd10;
        tick();
        checks++;
        if (draw !== 1'b1) begin errors++; $display("FAIL pre_reset_draw: got %0d expected 1", draw); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (paddle_y !== 9'd208) begin errors++; $display("FAIL midreset_y: got %0d expected 208", paddle_y); end
        checks++;
        if (state !== 2'd0) begin errors++; $display("FAIL midreset_state: got %0d expected 0", state); end
        checks++;
        if (draw !== 1'b0) begin errors++; $display("FAIL midreset_draw: got %0d expected 0", draw); end
        repeat (6) tick();
        checks++;
        if (paddle_y !== 9'd208 || state !== 2'd0) begin
            errors++; $display("FAIL midreset_hold: got y=%0d st=%0d expected y=208 st=0", paddle_y, state);
        end
        frames(1);
        checks++;
        if (paddle_y !== 9'd206 || state !== 2'd1) begin
            errors++; $display("FAIL after_reset_move: got y=%0d st=%0d expected y=206 st=1", paddle_y, state);
        end
        h_count = 10'd0; v_count = 10'd0;
    endtask

    task automatic test_reverse();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_buttons(1'b1, 1'b0);
        frames(28);
        checks++;
        if (paddle_y !== 9'd100 || state !== 2'd2) begin
            errors++; $display("FAIL up_to_100: got y=%0d st=%0d expected y=100 st=2", paddle_y, state);
        end
        set_buttons(1'b0, 1'b1);
        frames(1);
        checks++;
        if (paddle_y !== 9'd102 || state !== 2'd1) begin
            errors++; $display("FAIL reverse_down: got y=%0d st=%0d expected y=102 st=1", paddle_y, state);
        end
        set_buttons(1'b1, 1'b1);
        frames(1);
        checks++;
        if (paddle_y !== 9'd102 || state !== 2'd0) begin
            errors++; $display("FAIL both_idle: got y=%0d st=%0d expected y=102 st=0", paddle_y, state);
        end
    endtask

    task automatic test_no_frame_end();
        down = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            up = ~up;
            tick();
        end
        checks++;
        if (paddle_y !== 9'd102 || state !== 2'd0) begin
            errors++; $display("FAIL no_frame_end: got y=%0d st=%0d expected y=102 st=0", paddle_y, state);
        end
    endtask

    task automatic test_clamp_bottom();
        set_buttons(1'b0, 1'b1);
        frames(15);
        checks++;
        if (paddle_y !== 9'd132 || state !== 2'd1) begin
            errors++; $display("FAIL down_slow: got y=%0d st=%0d expected y=132 st=1", paddle_y, state);
        end
        frames(47);
        checks++;
        if (paddle_y !== 9'd414 || state !== 2'd2) begin
            errors++; $display("FAIL near_bottom: got y=%0d st=%0d expected y=414 st=2", paddle_y, state);
        end
        frames(1);
        checks++;
        if (paddle_y !== 9'd416) begin errors++; $display("FAIL clamp_bottom_y: got %0d expected 416", paddle_y); end
        frames(2);
        checks++;
        if (paddle_y !== 9'd416) begin errors++; $display("FAIL pinned_bottom_y: got %0d expected 416", paddle_y); end
        set_buttons(1'b0, 1'b0);
        frames(1);
        checks++;
        if (paddle_y !== 9'd416 || state !== 2'd0) begin
            errors++; $display("FAIL release_idle: got y=%0d st=%0d expected y=416 st=0", paddle_y, state);
        end
    endtask

    initial begin
        test_reset();
        test_draw();
        test_accel();
        test_clamp_top();
        test_reset_mid_frame();
        test_reverse();
        test_no_frame_end();
        test_clamp_bottom();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
